cache_access_scheduler: RTL and testbench
=========================================

Name: cache_access_scheduler

Overview:
- Shares the single lookup port of the cache simulator between NUM_REQ requesters using round-robin arbitration.
- Sequences each access: grant, issue, hit/miss classification, miss-penalty wait, response.
- Classifies each access as a hit or a miss from the simulator's running 31-bit hit and miss counters.
- Sits between the trace/request generators and the cache simulator. The simulator advances only when CacheEn_10 is high.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 31, address width; matches the simulator address port.
- MISS_PENALTY, 10, refill wait cycles after a miss (0 allowed).

Ports:
- Clock_10  in  1  clock; all state updates on posedge.
- Reset_10  in  1  asynchronous, active-low reset.
- Req_10  in  NUM_REQ  level request, one bit per requester.
- Addr_10  in  NUM_REQ*ADDR_W  request addresses; requester r occupies slice [r*ADDR_W +: ADDR_W].
- Gnt_10  out  NUM_REQ  one-hot, one-cycle grant pulse.
- Done_10  out  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- Hit_10  out  1  result for the current access; valid only while Done_10 is nonzero.
- Err_10  out  1  sticky classification error.
- Busy_10  out  1  high in every state except IDLE.
- CacheAddr_10  out  ADDR_W  address to the simulator.
- CacheEn_10  out  1  one-cycle lookup strobe to the simulator.
- CacheHitCnt_10  in  31  simulator running hit count.
- CacheMissCnt_10  in  31  simulator running miss count.

Behaviour:
- Reset (async, Reset_10=0):
  - FSM goes to IDLE.
  - All outputs are 0; CacheAddr_10 is 0.
  - Round-robin pointer last = NUM_REQ-1, so requester 0 has top priority after reset.
  - Reset asserted mid-access abandons that access: no Done_10 pulse is produced.
- FSM states: IDLE, ISSUE, CHECK, MISS_WAIT, RESP.
- IDLE:
  - If any Req_10 bit is set, grant the first set bit scanning (last+1, last+2, ...) mod NUM_REQ.
  - Gnt_10[r]=1 for this cycle.
  - At the edge: latch Addr_10 slice r; snapshot CacheHitCnt_10 and CacheMissCnt_10; set last=r; go to ISSUE.
  - No request: stay in IDLE; all pulse outputs 0.
- ISSUE:
  - CacheEn_10=1 and CacheAddr_10 = latched address for exactly one cycle; go to CHECK.
  - CacheAddr_10 holds the latched address from ISSUE until RESP; it is 0 in IDLE.
- CHECK:
  - Compute dh = CacheHitCnt_10 - snap_hit and dm = CacheMissCnt_10 - snap_miss, 31-bit modulo, so counter wrap from 2^31-1 to 0 is a +1 delta.
  - dh=1 and dm=0: hit; set res_hit=1; go to RESP.
  - dh=0 and dm=1: miss; res_hit=0. If MISS_PENALTY=0 go to RESP; otherwise load wait counter with MISS_PENALTY-1 and go to MISS_WAIT.
  - Any other delta pair: set Err_10 (sticky until reset); res_hit=0; go to RESP.
- MISS_WAIT:
  - Decrement the wait counter each cycle; when it reads 0, go to RESP.
  - Total MISS_WAIT cycles = MISS_PENALTY.
- RESP:
  - Done_10[r]=1 and Hit_10=res_hit for one cycle; go to IDLE.
- Latency, with the grant cycle as cycle 0:
  - Hit: Done_10 in cycle 3.
  - Miss: Done_10 in cycle 3+MISS_PENALTY.
  - Back-to-back throughput: one access per 4 cycles on hits.
- Handshake:
  - Req_10 is a level signal; addresses are sampled only at the grant edge, and later changes are ignored.
  - A requester still holding Req_10 in IDLE after its Done_10 is re-arbitrated normally. It cannot win twice in a row while any other requester is pending.
  - Requests raised during a busy period wait; only the IDLE state arbitrates.
- Simultaneous events:
  - Multiple requests in the same IDLE cycle are resolved by the round-robin rule alone.
  - Gnt_10 and Done_10 are never high together; at most one bit of each is set.

Test Plan:
- Single hit: requester 1 issues 0x40 twice, cache counters increment hit on the 2nd → 1st Done_10[1] with Hit_10=0 at cycle 3+MISS_PENALTY (=13); 2nd Done_10[1] with Hit_10=1 at cycle 3 after its grant.
- Fairness: Req_10=4'b1111 held after reset → grant order 0,1,2,3,0,… with one Gnt_10 per access, never two bits set.
- Counter wrap: CacheHitCnt_10 snapshot 0x7FFFFFFF, post-lookup value 0 → classified as a hit, Err_10 stays 0.
- Bad model response: both counters unchanged after CacheEn_10 → Err_10=1 (stays 1), Done_10 pulses with Hit_10=0.
- MISS_PENALTY=0 build: miss → Done_10 at cycle 3; exactly one CacheEn_10 pulse per access.
- Reset mid-MISS_WAIT: Reset_10 low for 1 cycle → all outputs 0 immediately, no Done_10; the next request from requester 0 is granted first.

Source files
------------

// File: rtl/cache_access_scheduler.sv
// Round-robin scheduler sharing the cache simulator lookup port between NUM_REQ requesters.
// Each access runs grant, issue, hit/miss classification, optional miss-penalty wait, response.
module cache_access_scheduler #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ADDR_W       = 31,
    parameter int unsigned MISS_PENALTY = 10
) (
    input  logic                      Clock_10,
    input  logic                      Reset_10,
    input  logic [NUM_REQ-1:0]        Req_10,
    input  logic [NUM_REQ*ADDR_W-1:0] Addr_10,
    output logic [NUM_REQ-1:0]        Gnt_10,
    output logic [NUM_REQ-1:0]        Done_10,
    output logic                      Hit_10,
    output logic                      Err_10,
    output logic                      Busy_10,
    output logic [ADDR_W-1:0]         CacheAddr_10,
    output logic                      CacheEn_10,
    input  logic [30:0]               CacheHitCnt_10,
    input  logic [30:0]               CacheMissCnt_10
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = (MISS_PENALTY > 1) ? $clog2(MISS_PENALTY) : 1;
    localparam int unsigned CTR_W = 31;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        CHECK,
        MISS_WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [IDX_W-1:0]   last;
    logic [IDX_W-1:0]   gnt_idx;
    logic [CTR_W-1:0]   snap_hit;
    logic [CTR_W-1:0]   snap_miss;
    logic [CNT_W-1:0]   wait_cnt;
    logic               res_hit;

    logic               arb_found_c;
    logic [IDX_W-1:0]   arb_idx_c;
    logic [ADDR_W-1:0]  addr_sel_c;
    logic [CTR_W-1:0]   dh_c;
    logic [CTR_W-1:0]   dm_c;
    int unsigned        idx;

    // Round-robin scan starting just after the last granted requester
    always_comb begin
        arb_found_c = 1'b0;
        arb_idx_c   = '0;
        addr_sel_c  = '0;
        idx         = 0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            idx = (32'(last) + i) % NUM_REQ;
            if (!arb_found_c && Req_10[IDX_W'(idx)]) begin
                arb_found_c = 1'b1;
                arb_idx_c   = IDX_W'(idx);
                addr_sel_c  = Addr_10[idx*ADDR_W +: ADDR_W];
            end
        end
    end

    // Counter deltas since the grant snapshot; modulo arithmetic absorbs counter wrap
    assign dh_c = CacheHitCnt_10  - snap_hit;
    assign dm_c = CacheMissCnt_10 - snap_miss;

    // Grant is visible during the arbitrating IDLE cycle itself, suppressed while in reset
    assign Gnt_10 = (state == IDLE && Reset_10 && arb_found_c)
                    ? (NUM_REQ'(1) << arb_idx_c) : '0;

    // Access sequencer with registered outputs
    always_ff @(posedge Clock_10 or negedge Reset_10) begin
        if (!Reset_10) begin
            state        <= IDLE;
            last         <= IDX_W'(NUM_REQ - 1);
            gnt_idx      <= '0;
            snap_hit     <= '0;
            snap_miss    <= '0;
            wait_cnt     <= '0;
            res_hit      <= 1'b0;
            Done_10      <= '0;
            Hit_10       <= 1'b0;
            Err_10       <= 1'b0;
            Busy_10      <= 1'b0;
            CacheAddr_10 <= '0;
            CacheEn_10   <= 1'b0;
        end else begin
            CacheEn_10 <= 1'b0;
            Done_10    <= '0;
            Hit_10     <= 1'b0;
            case (state)
                IDLE: begin
                    if (arb_found_c) begin
                        CacheAddr_10 <= addr_sel_c;
                        snap_hit     <= CacheHitCnt_10;
                        snap_miss    <= CacheMissCnt_10;
                        last         <= arb_idx_c;
                        gnt_idx      <= arb_idx_c;
                        CacheEn_10   <= 1'b1;
                        Busy_10      <= 1'b1;
                        state        <= ISSUE;
                    end
                end
                ISSUE: begin
                    state <= CHECK;
                end
                CHECK: begin
                    if (dh_c == CTR_W'(1) && dm_c == '0) begin
                        res_hit <= 1'b1;
                        Hit_10  <= 1'b1;
                        Done_10 <= NUM_REQ'(1) << gnt_idx;
                        state   <= RESP;
                    end else if (dh_c == '0 && dm_c == CTR_W'(1)) begin
                        res_hit <= 1'b0;
                        if (MISS_PENALTY == 0) begin
                            Done_10 <= NUM_REQ'(1) << gnt_idx;
                            state   <= RESP;
                        end else begin
                            wait_cnt <= CNT_W'(MISS_PENALTY - 1);
                            state    <= MISS_WAIT;
                        end
                    end else begin
                        Err_10  <= 1'b1;
                        res_hit <= 1'b0;
                        Done_10 <= NUM_REQ'(1) << gnt_idx;
                        state   <= RESP;
                    end
                end
                MISS_WAIT: begin
                    if (wait_cnt == '0) begin
                        Done_10 <= NUM_REQ'(1) << gnt_idx;
                        Hit_10  <= res_hit;
                        state   <= RESP;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    CacheAddr_10 <= '0;
                    Busy_10      <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cache_access_scheduler.sv
// Scoreboard bench for cache_access_scheduler: stimulus queues expectations, a monitor checks them.
module tb_cache_access_scheduler;

    localparam int NR = 4;
    localparam int AW = 31;
    localparam int MP = 10;
    localparam int M_HIT  = 0;
    localparam int M_MISS = 1;
    localparam int M_NONE = 2;

    typedef struct {
        int          r;
        logic [30:0] addr;
        logic        hit;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic [NR-1:0]     req;
    logic [NR*AW-1:0]  addr;
    logic [NR-1:0]     gnt, done;
    logic              hit, err, busy, cen;
    logic [AW-1:0]     caddr;
    logic [30:0]       hcnt, mcnt;

    logic [NR-1:0]     req0;
    logic [NR*AW-1:0]  addr0;
    logic [NR-1:0]     gnt0, done0;
    logic              hit0, err0, busy0, cen0;
    logic [AW-1:0]     caddr0;
    logic [30:0]       hcnt0, mcnt0;

    cache_access_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .MISS_PENALTY(MP)) u_dut (
        .Clock_10(clk), .Reset_10(rst_n), .Req_10(req), .Addr_10(addr),
        .Gnt_10(gnt), .Done_10(done), .Hit_10(hit), .Err_10(err), .Busy_10(busy),
        .CacheAddr_10(caddr), .CacheEn_10(cen),
        .CacheHitCnt_10(hcnt), .CacheMissCnt_10(mcnt)
    );

    cache_access_scheduler #(.NUM_REQ(NR), .ADDR_W(AW), .MISS_PENALTY(0)) u_dut0 (
        .Clock_10(clk), .Reset_10(rst_n), .Req_10(req0), .Addr_10(addr0),
        .Gnt_10(gnt0), .Done_10(done0), .Hit_10(hit0), .Err_10(err0), .Busy_10(busy0),
        .CacheAddr_10(caddr0), .CacheEn_10(cen0),
        .CacheHitCnt_10(hcnt0), .CacheMissCnt_10(mcnt0)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_cyc = 0;
    int          resp_mode = M_HIT;
    logic        preload = 1'b0;
    logic [30:0] preload_hit = '0;
    int          exp_gnt[$];
    exp_t        exp_done[$];
    int          m_g;
    exp_t        m_e;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural cache simulator counters
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            mcnt <= '0;
        end else if (preload) begin
            hcnt <= preload_hit;
        end else if (cen) begin
            if (resp_mode == M_HIT) hcnt <= hcnt + 31'd1;
            else if (resp_mode == M_MISS) mcnt <= mcnt + 31'd1;
        end
    end

    // Always-miss simulator for the zero-penalty instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt0 <= '0;
            mcnt0 <= '0;
        end else if (cen0) begin
            mcnt0 <= mcnt0 + 31'd1;
        end
    end

    // Monitor: compare grants, lookup address and responses against the queues
    always @(negedge clk) begin
        if (gnt != 0 && done != 0) chk("gnt_done_exclusive", {gnt, done}, 0);
        if (gnt != 0) begin
            if (exp_gnt.size() == 0) begin
                chk("gnt_unexpected", 64'(gnt), 0);
            end else begin
                m_g = exp_gnt.pop_front();
                chk("gnt_vec", 64'(gnt), 64'(4'b0001 << m_g));
            end
            gnt_cyc = cyc;
        end
        if (cen && exp_done.size() != 0) chk("cache_addr", 64'(caddr), 64'(exp_done[0].addr));
        if (done != 0) begin
            if (exp_done.size() == 0) begin
                chk("done_unexpected", 64'(done), 0);
            end else begin
                m_e = exp_done.pop_front();
                chk("done_vec", 64'(done), 64'(4'b0001 << m_e.r));
                chk("hit", 64'(hit), 64'(m_e.hit));
                chk("latency", 64'(cyc - gnt_cyc), 64'(m_e.lat));
            end
        end
    end

    task automatic wait_gnt(input int r);
        bit ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            @(negedge clk);
            if (gnt[r]) ok = 1;
        end
        if (!ok) chk("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done_empty();
        for (int k = 0; k < 200 && exp_done.size() != 0; k++) @(negedge clk);
        if (exp_done.size() != 0) begin
            chk("done_timeout", 64'(exp_done.size()), 0);
            exp_done.delete();
        end
        exp_gnt.delete();
    endtask

    task automatic push_exp(input int r, input logic [30:0] a, input logic h, input int lat);
        exp_t e;
        e.r = r; e.addr = a; e.hit = h; e.lat = lat;
        exp_gnt.push_back(r);
        exp_done.push_back(e);
    endtask

    task automatic do_access(input int r, input logic [30:0] a, input int mode,
                             input logic exp_hit, input int lat);
        push_exp(r, a, exp_hit, lat);
        @(posedge clk); #1;
        resp_mode = mode;
        addr[r*AW +: AW] = a;
        req[r] = 1'b1;
        wait_gnt(r);
        @(posedge clk); #1;
        req[r] = 1'b0;
        chk("busy_after_grant", 64'(busy), 1);
        wait_done_empty();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},   64'(gnt), 0);
        chk({tag, "_done"},  64'(done), 0);
        chk({tag, "_hit"},   64'(hit), 0);
        chk({tag, "_err"},   64'(err), 0);
        chk({tag, "_busy"},  64'(busy), 0);
        chk({tag, "_en"},    64'(cen), 0);
        chk({tag, "_caddr"}, 64'(caddr), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        exp_gnt.delete();
        exp_done.delete();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int g0, en_cnt, done_cnt, d_cyc;
    logic d_hit;

    initial begin
        rst_n = 1'b0; req = '0; addr = '0; req0 = '0; addr0 = '0;
        repeat (2) @(negedge clk);
        req = 4'b0100;
        #1;
        check_all_zero("reset");
        @(negedge clk);
        req = '0;
        rst_n = 1'b1;

        // Miss then hit from requester 1 at 0x40
        do_access(1, 31'h40, M_MISS, 1'b0, 3 + MP);
        do_access(1, 31'h40, M_HIT,  1'b1, 3);
        chk("err_after_hitmiss", 64'(err), 0);

        // Fairness with all four requesting continuously
        do_reset();
        for (int i = 0; i < 6; i++) push_exp(i % NR, 31'((i % NR + 1) * 'h100), 1'b1, 3);
        @(posedge clk); #1;
        resp_mode = M_HIT;
        for (int r = 0; r < NR; r++) addr[r*AW +: AW] = 31'((r + 1) * 'h100);
        req = 4'b1111;
        for (int k = 0; k < 100 && exp_gnt.size() != 0; k++) @(negedge clk);
        chk("fair_all_granted", 64'(exp_gnt.size()), 0);
        @(posedge clk); #1;
        req = '0;
        wait_done_empty();

        // Hit counter wraps from 2^31-1 to 0
        @(posedge clk); #1;
        preload_hit = 31'h7FFF_FFFF;
        preload = 1'b1;
        @(posedge clk); #1;
        preload = 1'b0;
        do_access(2, 31'h1234, M_HIT, 1'b1, 3);
        chk("err_after_wrap", 64'(err), 0);

        // Simulator fails to move either counter
        do_access(3, 31'h55, M_NONE, 1'b0, 3);
        chk("err_set", 64'(err), 1);
        do_access(0, 31'h66, M_HIT, 1'b1, 3);
        chk("err_sticky", 64'(err), 1);

        // Reset during the miss wait abandons the access
        exp_gnt.push_back(2);
        @(posedge clk); #1;
        resp_mode = M_MISS;
        addr[2*AW +: AW] = 31'h777;
        req[2] = 1'b1;
        wait_gnt(2);
        @(posedge clk); #1;
        req[2] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("busy_in_wait", 64'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_all_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (15) @(negedge clk);
        push_exp(0, 31'h70, 1'b1, 3);
        @(posedge clk); #1;
        resp_mode = M_HIT;
        addr[0 +: AW] = 31'h70;
        addr[3*AW +: AW] = 31'h73;
        req = 4'b1001;
        wait_gnt(0);
        @(posedge clk); #1;
        req = '0;
        wait_done_empty();

        // Zero-penalty build: miss answered in cycle 3 with a single lookup strobe
        @(posedge clk); #1;
        addr0[0 +: AW] = 31'h99;
        req0[0] = 1'b1;
        g0 = -1;
        for (int k = 0; k < 20 && g0 < 0; k++) begin
            @(negedge clk);
            if (gnt0[0]) g0 = cyc;
        end
        chk("mp0_granted", 64'(g0 >= 0), 1);
        @(posedge clk); #1;
        req0 = '0;
        en_cnt = 0; done_cnt = 0; d_cyc = -1; d_hit = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (cen0) en_cnt++;
            if (done0 != 0) begin
                done_cnt++;
                d_cyc = cyc;
                d_hit = hit0;
                chk("mp0_done_vec", 64'(done0), 1);
            end
        end
        chk("mp0_latency", 64'(d_cyc - g0), 3);
        chk("mp0_hit", 64'(d_hit), 0);
        chk("mp0_en_pulses", 64'(en_cnt), 1);
        chk("mp0_done_pulses", 64'(done_cnt), 1);
        chk("mp0_err", 64'(err0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
